// File: rtl/stream_merge_shell.sv
// stream_merge_shell: NUM_CHANNELS valid/ready input streams, each buffered in
// its own register-array FIFO, merged round-robin into one registered output
// stream tagged with the source channel index.

// Per-channel FIFO: register storage, wrapping pointers, occupancy counter.
module stream_merge_shell_fifo #(
  parameter int PAYLOAD_BITS  = 64,
  parameter int NUM_ADDR_BITS = 4,
  parameter int AFULL_THRESH  = 14
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    live,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [PAYLOAD_BITS-1:0] wdata,
  output logic [PAYLOAD_BITS-1:0] rdata,
  output logic                    empty,
  output logic                    ready,
  output logic                    almost_full
);
  localparam int DEPTH = 2**NUM_ADDR_BITS;

  logic [DEPTH-1:0][PAYLOAD_BITS-1:0] mem;
  logic [NUM_ADDR_BITS-1:0]           wr_ptr, rd_ptr;
  logic [NUM_ADDR_BITS:0]             count;
  logic                               full;

  assign full  = (count == DEPTH[NUM_ADDR_BITS:0]);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];
  // live is low until the first edge after reset release, so the channel
  // advertises nothing while held in reset.
  assign ready       = live && !full;
  assign almost_full = live && (count >= AFULL_THRESH[NUM_ADDR_BITS:0]);

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; simultaneous rd/wr leaves count alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module stream_merge_shell #(
  parameter  int PAYLOAD_BITS  = 64,
  parameter  int NUM_CHANNELS  = 4,
  parameter  int NUM_ADDR_BITS = 4,
  parameter  int AFULL_THRESH  = (2**NUM_ADDR_BITS) - 2,
  localparam int CHAN_BITS     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_CHANNELS*PAYLOAD_BITS-1:0] din,
  input  logic [NUM_CHANNELS-1:0]              val_in,
  output logic [NUM_CHANNELS-1:0]              ready_upward,
  output logic [NUM_CHANNELS-1:0]              almost_full,
  output logic [PAYLOAD_BITS-1:0]              dout,
  output logic [CHAN_BITS-1:0]                 dout_chan,
  output logic                                 val_out,
  input  logic                                 ready_downward
);
  logic [NUM_CHANNELS-1:0][PAYLOAD_BITS-1:0] din_arr, rdata_arr;
  logic [NUM_CHANNELS-1:0]                   wr, rd, empty;
  logic [CHAN_BITS-1:0]                      grant, last_grant;
  logic                                      any_ne, load, live;

  // Goes high on the first edge after reset release and stays there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) live <= 1'b0;
    else          live <= 1'b1;
  end

  genvar i;
  generate
    for (i = 0; i < NUM_CHANNELS; i++) begin : g_chan
      assign din_arr[i] = din[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      assign wr[i]      = val_in[i] && ready_upward[i];
      assign rd[i]      = load && (grant == CHAN_BITS'(i));

      stream_merge_shell_fifo #(
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .NUM_ADDR_BITS(NUM_ADDR_BITS),
        .AFULL_THRESH (AFULL_THRESH)
      ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .live       (live),
        .wr         (wr[i]),
        .rd         (rd[i]),
        .wdata      (din_arr[i]),
        .rdata      (rdata_arr[i]),
        .empty      (empty[i]),
        .ready      (ready_upward[i]),
        .almost_full(almost_full[i])
      );
    end
  endgenerate

  // Round-robin pick: first non-empty channel after last_grant. Iterating
  // from the farthest offset down lets the nearest candidate win.
  always_comb begin
    grant = last_grant;
    for (int k = NUM_CHANNELS; k >= 1; k--) begin
      int idx;
      idx = (int'(last_grant) + k) % NUM_CHANNELS;
      if (!empty[idx]) grant = CHAN_BITS'(idx);
    end
  end

  assign any_ne = |(~empty);
  assign load   = (!val_out || ready_downward) && any_ne;

  // Output register: load on a free slot, drop valid once drained, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_out    <= 1'b0;
      dout       <= '0;
      dout_chan  <= '0;
      last_grant <= CHAN_BITS'(NUM_CHANNELS - 1);
    end else if (load) begin
      val_out    <= 1'b1;
      dout       <= rdata_arr[grant];
      dout_chan  <= grant;
      last_grant <= grant;
    end else if (ready_downward) begin
      val_out    <= 1'b0;
    end
  end

  // A pop must never target an empty channel.
  a_pop_nonempty: assert property (@(posedge clk) disable iff (!reset_n)
    load |-> !empty[grant]);

  // A stalled output word stays put until accepted.
  a_stall_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (val_out && !ready_downward) |=> (val_out && $stable(dout) && $stable(dout_chan)));
endmodule

// File: tb/tb_stream_merge_shell.sv
// Scoreboard bench for stream_merge_shell: stimulus pushes expected
// (channel, word) pairs, a monitor pops them on every output handshake.
module tb_stream_merge_shell;
  localparam int PB = 64;
  localparam int NC = 4;

  typedef struct packed {
    logic [1:0]    chan;
    logic [PB-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NC*PB-1:0] din = '0;
  logic [NC-1:0]    val_in = '0;
  logic [NC-1:0]    ready_upward, almost_full;
  logic [PB-1:0]    dout;
  logic [1:0]       dout_chan;
  logic             val_out;
  logic             ready_downward = 1'b0;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  stream_merge_shell #(.PAYLOAD_BITS(PB), .NUM_CHANNELS(NC), .NUM_ADDR_BITS(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .din           (din),
    .val_in        (val_in),
    .ready_upward  (ready_upward),
    .almost_full   (almost_full),
    .dout          (dout),
    .dout_chan     (dout_chan),
    .val_out       (val_out),
    .ready_downward(ready_downward)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input int c, input logic [PB-1:0] d);
    exp_t e;
    e.chan = 2'(c);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && val_out && ready_downward) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got chan=%0d data=%h, required no word", dout_chan, dout);
        end else begin
          e = exp_q.pop_front();
          if (dout_chan !== e.chan || dout !== e.data) begin
            errors++;
            $display("FAIL output_word: got chan=%0d data=%h, required chan=%0d data=%h",
                     dout_chan, dout, e.chan, e.data);
          end
        end
      end
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_n = 1'b0;
    val_in = '0;
    din = '0;
    ready_downward = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the scoreboard empties, then the output must idle.
  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_idle"}, {63'd0, val_out}, 64'd0);
  endtask

  initial begin
    // ---- reset state and single word latency ----
    repeat (3) begin
      @(negedge clk);
      chk("rst_val_out", {63'd0, val_out}, 64'd0);
      chk("rst_dout", dout, 64'd0);
      chk("rst_chan_ready_af", {58'd0, dout_chan, ready_upward[1:0] | almost_full[1:0]} | 64'(ready_upward) | 64'(almost_full), 64'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("ready_before_edge", 64'(ready_upward), 64'h0);
    @(posedge clk);
    #1 chk("ready_after_release", 64'(ready_upward), 64'hF);

    val_in[2] = 1'b1;
    din[2*PB +: PB] = 64'hA5;
    @(posedge clk);                       // edge k: word captured
    #1;
    val_in = '0;
    chk("latency_not_yet", {63'd0, val_out}, 64'd0);
    @(posedge clk);                       // edge k+1: word on output
    #1;
    chk("single_val_out", {63'd0, val_out}, 64'd1);
    chk("single_dout", dout, 64'hA5);
    chk("single_chan", 64'(dout_chan), 64'd2);
    push(2, 64'hA5);
    ready_downward = 1'b1;
    drain("single", 10);

    // ---- fill and backpressure on ch0 ----
    // The first word moves into the output register, so 17 words are taken
    // before the FIFO itself holds 16.
    do_reset();
    val_in[0] = 1'b1;
    din[0 +: PB] = 64'd0;
    for (int j = 0; j <= 16; j++) begin
      int c;
      @(posedge clk);
      push(0, 64'(j));
      #1;
      c = (j == 0) ? 1 : j;
      chk($sformatf("fill_af_%0d", j), {63'd0, almost_full[0]}, {63'd0, c >= 14});
      chk($sformatf("fill_ready_%0d", j), {63'd0, ready_upward[0]}, {63'd0, c < 16});
      din[0 +: PB] = 64'(j + 1);
    end
    repeat (3) begin                      // word 17 held but never taken
      @(posedge clk);
      #1 chk("full_not_ready", {63'd0, ready_upward[0]}, 64'd0);
    end
    val_in = '0;
    ready_downward = 1'b1;
    repeat (17) @(posedge clk);           // back-to-back transfers
    #1;
    chk("fill_consecutive_pending", 64'(exp_q.size()), 64'd0);
    chk("fill_consecutive_idle", {63'd0, val_out}, 64'd0);

    // ---- round-robin ----
    do_reset();
    for (int w = 0; w < 3; w++) begin
      val_in = 4'hF;
      for (int c = 0; c < NC; c++) din[c*PB +: PB] = 64'(256 + c*16 + w);
      @(posedge clk);
      #1;
    end
    val_in = '0;
    for (int w = 0; w < 3; w++)
      for (int c = 0; c < NC; c++) push(c, 64'(256 + c*16 + w));
    @(posedge clk);
    #1;
    ready_downward = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("rr_pending", 64'(exp_q.size()), 64'd0);
    chk("rr_val_drop", {63'd0, val_out}, 64'd0);

    // ---- output stall ----
    do_reset();
    val_in = 4'b0010;
    din[1*PB +: PB] = 64'h33;
    @(posedge clk);
    #1;
    val_in = 4'b0101;
    din[0*PB +: PB] = 64'h44;
    din[2*PB +: PB] = 64'h55;
    @(posedge clk);
    #1;
    val_in = '0;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk);
      #1;
      chk("stall_val", {63'd0, val_out}, 64'd1);
      chk("stall_dout", dout, 64'h33);
      chk("stall_chan", 64'(dout_chan), 64'd1);
    end
    push(1, 64'h33);                      // then ch2 (after 1), then ch0
    push(2, 64'h55);
    push(0, 64'h44);
    ready_downward = 1'b1;
    drain("stall", 10);

    // ---- simultaneous read/write on ch1 ----
    do_reset();
    val_in[1] = 1'b1;
    for (int j = 0; j < 21; j++) begin
      din[1*PB +: PB] = 64'(512 + j);
      @(posedge clk);
      push(1, 64'(512 + j));
      #1;
      if (j >= 9) begin                   // count held at 8
        chk("rw_af", {63'd0, almost_full[1]}, 64'd0);
        chk("rw_ready", {63'd0, ready_upward[1]}, 64'd1);
      end
      if (j == 8) ready_downward = 1'b1;
    end
    val_in = '0;
    drain("rw", 20);

    // ---- wrap-around: 40 words on ch3 with mixed output stalls ----
    do_reset();
    begin
      bit wdone = 1'b0;
      fork
        begin
          int   sent = 0;
          int   cyc = 0;
          logic cur_rdy;
          val_in[3] = 1'b1;
          din[3*PB +: PB] = 64'h300;
          cur_rdy = ready_upward[3];
          while (sent < 40 && cyc < 600) begin
            @(posedge clk);
            if (cur_rdy) begin
              push(3, 64'(768 + sent));
              sent++;
            end
            cyc++;
            #1;
            cur_rdy = ready_upward[3];
            if (sent < 40) din[3*PB +: PB] = 64'(768 + sent);
            else val_in = '0;
          end
          val_in = '0;
          chk("wrap_sent", 64'(sent), 64'd40);
          wdone = 1'b1;
        end
        begin
          int i = 0;
          while (!wdone) begin
            @(posedge clk);
            #1;
            ready_downward = ((i % 7) < 3);
            i++;
          end
        end
      join
    end
    ready_downward = 1'b1;
    drain("wrap", 100);

    // ---- reset mid-traffic ----
    do_reset();
    val_in[0] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      din[0 +: PB] = 64'(1024 + j);
      @(posedge clk);
      #1;
    end
    val_in = '0;
    chk("mid_val_before", {63'd0, val_out}, 64'd1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;                       // between edges
    #1;
    chk("mid_val_async", {63'd0, val_out}, 64'd0);
    chk("mid_dout_async", dout, 64'd0);
    chk("mid_ready_async", 64'(ready_upward), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ready_downward = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_no_stale", {63'd0, val_out}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
